// File: rtl/finv_arbiter.sv
// finv_arbiter: round-robin sharing of one pipelined finv unit among NREQ requesters.
// Optional per-requester issue counters are built when FINV_ARB_STATS_EN is defined.
module finv_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*32-1:0]  req_x,
    output logic [NREQ-1:0]     req_ready,
    output logic [31:0]         finv_x,
    input  logic [31:0]         finv_y,
    output logic [NREQ-1:0]     resp_valid,
    output logic [NREQ*32-1:0]  resp_y,
    input  logic [NREQ-1:0]     resp_ready
`ifdef FINV_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]  stat_issue
`endif
);

    logic [NREQ-1:0] busy_s;
    logic [NREQ-1:0] elig_s;
    logic            grant_vld_s;
    logic [IW-1:0]   grant_idx_s;
    logic [IW:0]     cand_s;
    logic [IW-1:0]   cidx_s;
    logic [IW-1:0]   ptr_r;
    logic [LAT-1:0]  tag_vld_r;
    logic [IW-1:0]   tag_idx_r [LAT];

    // A requester is busy while it owns an in-flight op or an unread result.
    always_comb begin
        busy_s = resp_valid;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < LAT; j++) begin
                if (tag_vld_r[j] && (tag_idx_r[j] == IW'(i))) begin
                    busy_s[i] = 1'b1;
                end else begin
                    busy_s[i] = busy_s[i];
                end
            end
        end
        elig_s = req_valid & ~busy_s;
    end

    // Rotating-priority search from ptr_r; the wrap is explicit for non-power-of-two NREQ.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        cidx_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr_r} + (IW+1)'(k);
            if (cand_s >= (IW+1)'(NREQ)) begin
                cand_s = cand_s - (IW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            cidx_s = cand_s[IW-1:0];
            if (!grant_vld_s && elig_s[cidx_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cidx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Handshake and operand mux; an idle slot feeds zero into finv.
    always_comb begin
        req_ready = '0;
        finv_x    = 32'h0000_0000;
        if (grant_vld_s) begin
            req_ready[grant_idx_s] = 1'b1;
            finv_x                 = req_x[{grant_idx_s, 5'd0} +: 32];
        end else begin
            req_ready = '0;
            finv_x    = 32'h0000_0000;
        end
    end

    // Round-robin pointer, owner tag pipe and per-requester result buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= '0;
            tag_vld_r  <= '0;
            for (int j = 0; j < LAT; j++) begin
                tag_idx_r[j] <= '0;
            end
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            if (grant_vld_s) begin
                ptr_r <= (grant_idx_s == IW'(NREQ-1)) ? '0 : grant_idx_s + IW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            tag_vld_r[0] <= grant_vld_s;
            tag_idx_r[0] <= grant_idx_s;
            for (int j = 1; j < LAT; j++) begin
                tag_vld_r[j] <= tag_vld_r[j-1];
                tag_idx_r[j] <= tag_idx_r[j-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (tag_vld_r[LAT-1] && (tag_idx_r[LAT-1] == IW'(i))) begin
                    resp_valid[i]        <= 1'b1;
                    resp_y[32*i +: 32]   <= finv_y;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i]        <= 1'b0;
                end else begin
                    resp_valid[i]        <= resp_valid[i];
                end
            end
        end
    end

`ifdef FINV_ARB_STATS_EN
    // Per-requester grant counters; 16-bit wrap is intentional.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issue <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    stat_issue[16*i +: 16] <= stat_issue[16*i +: 16] + 16'd1;
                end else begin
                    stat_issue[16*i +: 16] <= stat_issue[16*i +: 16];
                end
            end
        end
    end
`endif

endmodule

// File: doc/finv_arbiter.md
# finv_arbiter

Round-robin arbiter sharing one pipelined `finv` reciprocal unit among `NREQ` independent requesters. It issues at most one operand per cycle into `finv` and tracks the owner of each in-flight operation with a tag shift register matched to the unit's latency. Each requester gets its result back in a private one-entry result buffer with a valid/ready handshake. It sits between the FPU issue ports (e.g. the scalar `fdiv` sequencer and the vector lane) and the single shared `finv` instance.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `LAT`, 2: `finv` latency in clock edges from operand to result; must equal the `finv` `NSTAGE`.
- `IW`, `$clog2(NREQ)`: tag index width (derived, not overridden).

- `clk`  in  1  clock, shared with `finv`.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i presents an operand.
- `req_x`  in  NREQ*32  operand of requester i in bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot or zero; operand accepted this cycle.
- `finv_x`  out  32  operand driven into `finv.x`.
- `finv_y`  in  32  `finv.y`.
- `resp_valid`  out  NREQ  result buffer i full.
- `resp_y`  out  NREQ*32  result of requester i, stable while `resp_valid[i]`.
- `resp_ready`  in  NREQ  requester i consumes its result.
- `stat_issue`  out  NREQ*16  per-requester issue counters; present only with `FINV_ARB_STATS_EN`.

## Operation
- Per requester: `busy[i]` = op in flight for i OR `resp_valid[i]`. Eligible = `req_valid[i] & ~busy[i]`.
- Grant: the first eligible index searching from `ptr`, then `ptr+1`, ... wrapping modulo NREQ. `req_ready` is combinational from `req_valid` and is asserted only for the granted index. At most one grant per cycle.
- On a grant to g: `ptr <= (g+1) mod NREQ`, and tag `{1, g}` enters stage 0 of the tag pipe. With no grant, `ptr` holds and `{0, x}` enters.
- `finv_x` = `req_x` of the granted requester. With no grant, `finv_x` = 0. This result is not tagged and is discarded.
- The tag pipe is `LAT` registers deep and shifts every cycle (no stall; `finv` never stalls).
- When the tag at stage `LAT-1` is valid with index k, `finv_y` is captured into result buffer k and `resp_valid[k]` sets at that edge.
- `resp_valid[i]` clears on an edge where `resp_valid[i] & resp_ready[i]`. Set and clear cannot coincide for one i (one outstanding op per requester).
- The block passes results through unmodified. Specials (zero→inf, inf→zero) come from `finv`.
- `ptr` is `IW` bits. The wrap from NREQ-1 to 0 must be explicit when NREQ is not a power of two.

## Timing
- Reset (async, immediate): `ptr`=0, all tags invalid, `resp_valid`=0, `resp_y`=0, `stat_issue`=0. Combinational outputs follow: `req_ready`=0 until a valid is seen, `finv_x`=0.
- Accept on cycle t: `resp_valid[i]` is high from cycle t+LAT+1.
- Issue throughput: 1 op/cycle across requesters; per requester, 1 op per LAT+2 cycles minimum. Re-issue is allowed the cycle after the response pops.
- A held result blocks only its own requester.
- Reset mid-operation: in-flight ops and buffered results are dropped. Requesters must re-issue.
- `req_x` may change freely when `req_ready` is low.

## Configuration
- `FINV_ARB_STATS_EN` defined: adds `stat_issue`. Counter i increments on each grant to i, wraps at 0xFFFF→0, and resets to 0.
- Undefined: port and counters absent; all other behaviour identical.

## Test plan
- Single request: r0 sends 0x40000000 at t → `req_ready[0]`=1 at t; `resp_valid[0]`=1 at t+3 with `resp_y[0]`=0x3F000000; pop → `resp_valid[0]`=0 next cycle.
- All four valid at once with 0x3F800000, 0x40000000, 0x40800000, 0x00000000, ptr=0 → grants 0,1,2,3 on consecutive cycles. Results are 0x3F800000, 0x3F000000, 0x3E800000, 0x7F800000, each 3 cycles after its own grant.
- Backpressure: r1 holds `resp_ready`=0 while requesting continuously → no second grant to r1; r0 and r2 keep being granted round-robin; r1 is re-granted the cycle after its pop.
- Fairness: r0 and r3 always valid with immediate pops → grants alternate 0,3,0,3; neither waits more than NREQ cycles.
- Async `rst` asserted mid-flight between grant and result → `resp_valid`=0 immediately; no stale result appears after release; the first post-reset grant goes to the lowest valid index.
- With `FINV_ARB_STATS_EN`: 70000 grants to r2 → `stat_issue[47:32]`=4464 (70000 mod 65536).
